// File: rtl/mips_icache_direct.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Hits answer one cycle after the accepting edge. A miss holds a single-word
// read toward the backing memory until mem_dvalid, then fills the line and
// forwards the word to the CPU.
module mips_icache_direct #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_read,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        flush,
    output logic [31:0] mem_addr,
    output logic        mem_read_en,
    input  logic [31:0] mem_data,
    input  logic        mem_dvalid,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    // Tag width follows from the index width; it is deliberately not a
    // parameter so the address split can never be made inconsistent.
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Line storage. Only the valid bits are control state; tags and data are
    // meaningless while their valid bit is clear, so they carry no reset.
    logic [LINES-1:0]    valid_bits;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    // Word address of the outstanding miss (byte offset dropped).
    logic [29:0] req_word;

    // The byte offset never selects anything in a word-per-line cache.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^cpu_addr[1:0];

    // Lookup side: combinational decode of the presented CPU address.
    logic [INDEX_BITS-1:0] lookup_index;
    logic [TAG_BITS-1:0]   lookup_tag;
    logic                  lookup_hit;

    assign lookup_index = cpu_addr[INDEX_BITS+1:2];
    assign lookup_tag   = cpu_addr[31:INDEX_BITS+2];
    assign lookup_hit   = valid_bits[lookup_index] && (tag_mem[lookup_index] == lookup_tag);

    // Fill side: decode of the latched miss address.
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;

    assign req_index = req_word[INDEX_BITS-1:0];
    assign req_tag   = req_word[29:INDEX_BITS];

    // Handshake qualifiers.
    logic accept;
    logic accept_hit;
    logic accept_miss;
    logic fill;

    assign cpu_ready   = (state == IDLE);
    assign accept      = cpu_read && cpu_ready;
    assign accept_hit  = accept && lookup_hit;
    assign accept_miss = accept && !lookup_hit;
    assign fill        = (state == MISS) && mem_dvalid;

    // Memory request: held for the whole miss, but dropped in the data-valid
    // cycle so the memory does not see a fresh read at the fill edge.
    assign mem_read_en = (state == MISS) && !mem_dvalid;
    assign mem_addr    = {req_word, 2'b00};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a miss parks the FSM until memory answers.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_miss) begin
                    state_next = MISS;
                end
            end
            MISS: begin
                if (mem_dvalid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Valid bits: flush clears everything, but a fill on the same edge still
    // marks its own line valid because the fill write is applied last.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_bits <= '0;
        end else begin
            if (flush) begin
                valid_bits <= '0;
            end
            if (fill) begin
                valid_bits[req_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are written only when a miss completes.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[req_index]  <= req_tag;
            data_mem[req_index] <= mem_data;
        end
    end

    // Capture the miss address; it stays put until the next accepted miss so
    // mem_addr is stable for the whole memory transaction.
    always_ff @(posedge clk) begin
        if (accept_miss) begin
            req_word <= cpu_addr[31:2];
        end
    end

    // CPU response: a single-cycle valid pulse per accepted request, from the
    // array on a hit or straight from memory on the fill edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            if (accept_hit) begin
                cpu_rvalid <= 1'b1;
                cpu_rdata  <= data_mem[lookup_index];
            end else if (fill) begin
                cpu_rvalid <= 1'b1;
                cpu_rdata  <= mem_data;
            end
        end
    end

    // Hit/miss statistics on accepted requests; both wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (accept_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (accept_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule
